alu_multiciclo: RTL and testbench
=================================

// Module: alu_multiciclo
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle combinational ALU in the JOF32 execute stage.
//  - Same 5-bit opcode encoding.
//  - Adds an iterative shift-add MULT and a restoring DIV, a completed NOR, branch compare and status flags.
//  - Execute-stage control issues one op via valid/ready, stalls while busy, then consumes the result.
// PARAMETERS
//  WIDTH  32  operand/result width, >=8; iteration counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      op request valid
//  in_ready   out  1      ALU can accept op (state==IDLE)
//  opcode     in   5      ADD=1 SUB=2 AND=3 OR=4 NOR=5 SLL=6 SRL=7 MULT=8 DIV=9 BEQ=10 BNE=11 LW=12 LB=13 SW=14 ADDI=15 J=16 NOP=31
//  a, b       in   WIDTH  operands, sampled only on accept
//  out_valid  out  1      result/flags valid (state==DONE)
//  out_ready  in   1      consumer takes result
//  resultado  out  WIDTH  result, held stable while out_valid
//  zero       out  1      resultado==0
//  ovf        out  1      signed overflow, ADD/ADDI/SUB only, else 0
//  div0       out  1      DIV with b==0
//  busy       out  1      state==BUSY
// BEHAVIOUR
//  - Reset: state=IDLE; resultado=0, zero=0, ovf=0, div0=0, out_valid=0, busy=0; in_ready=1 during/after reset.
//    Reset mid-operation aborts it; the op is lost and never reported.
//  - Accept when in_valid && in_ready; a, b, opcode latched. Inputs ignored outside IDLE.
//  - FSM: IDLE -(accept, 1-cycle op)-> DONE; IDLE -(accept MULT, or DIV with b!=0)-> BUSY;
//    BUSY -(count reaches WIDTH)-> DONE; DONE -(out_ready)-> IDLE. No back-to-back overlap.
//  - Latency, accept edge N to out_valid high:
//    1-cycle ops: edge N+1. Iterative MULT/DIV: edge N+1+WIDTH.
//  - 1-cycle ops:
//    ADD/ADDI/LW/LB/SW: a+b. SUB: a-b. AND, OR as named. NOR: ~(a|b).
//    SLL/SRL: logical shift by unsigned b; result 0 if b>=WIDTH.
//    BEQ/BNE: a-b, so zero=1 iff a==b. J/NOP/undefined opcode: 0.
//  - ADD/SUB arithmetic: modulo 2^WIDTH.
//    ovf = operands share sign and result sign differs (ADD); for SUB, a and ~b share sign and result sign differs.
//  - MULT: unsigned shift-add, one multiplier bit per cycle, result = low WIDTH bits of product.
//  - DIV: unsigned restoring, one quotient bit per cycle, result = quotient; remainder discarded.
//    b==0: 1-cycle path, resultado = all ones, div0=1.
//  - DONE holds resultado/flags stable until out_ready sampled high; IDLE next cycle.
//    out_valid and in_ready are never high together.
//  - Flags update together with resultado; hold otherwise.
// CONFIGURATION
//  ALU_FAST_MULT_EN defined: MULT uses combinational a*b and is a 1-cycle op (out_valid at N+1); DIV still iterative.
//  ALU_FAST_MULT_EN undefined: MULT is iterative, out_valid at N+1+WIDTH; no WIDTH x WIDTH multiplier inferred.
// TESTING
//  1. ADD a=5 b=3 -> resultado=8, zero=0, ovf=0, out_valid at N+1; then SUB 3-3 -> 0, zero=1.
//  2. ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, ovf=1.
//     SUB 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
//     NOR 0xF0F0F0F0,0x0F0F0000 -> 0x00000F0F. SLL 1 by 40 -> 0.
//  3. MULT 1234*5678 -> 7006652.
//     Macro off: out_valid at N+33, busy=1 for 32 cycles, in_ready=0 throughout.
//     Macro on: out_valid at N+1.
//     MULT 0xFFFFFFFF*2 -> 0xFFFFFFFE.
//  4. DIV 100/7 -> 14 at N+33. DIV 0xFFFFFFFF/1 -> 0xFFFFFFFF, div0=0.
//     DIV 5/0 -> 0xFFFFFFFF, div0=1 at N+1.
//  5. Backpressure: out_ready=0 for 3 cycles after result -> resultado/flags stable, out_valid=1, in_ready=0.
//     New in_valid during the stall is not accepted.
//  6. Assert rst_n low 10 cycles into a DIV -> all outputs 0 immediately; after release in_ready=1, no stale out_valid.
//     Next ADD 2+2 -> 4.

Source files
------------

// File: rtl/alu_multiciclo.sv
// -----------------------------------------------------------------------------
// alu_multiciclo
//
// Handshaked multi-cycle ALU for the JOF32 execute stage. One operation is
// accepted through in_valid/in_ready. Most opcodes complete in one cycle. MULT
// (unsigned shift-add) and DIV (unsigned restoring) iterate one bit per cycle
// for WIDTH cycles. The result and flags are then held until out_ready.
//
// Parameters
//   WIDTH      operand/result width (>= 8)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid            in_ready   ALU idle, can accept
//   opcode     5-bit operation code     a, b       operands (sampled on accept)
//   out_valid  result valid             out_ready  consumer takes result
//   resultado  result                   zero       resultado == 0
//   ovf        signed overflow (ADD/ADDI/SUB)
//   div0       DIV with b == 0          busy       iterative op in progress
//
// Build option
//   ALU_FAST_MULT_EN  when defined, MULT uses a combinational a*b and completes
//                     in one cycle. When undefined, MULT is iterative and no
//                     WIDTH x WIDTH multiplier is built.
//
// State table
//   IDLE | waiting for a request, in_ready high
//   BUSY | iterating MULT/DIV, one bit per cycle
//   DONE | result/flags valid, waiting for out_ready
// -----------------------------------------------------------------------------
module alu_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultado,
    output logic             zero,
    output logic             ovf,
    output logic             div0,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;

    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_NOR  = 5'd5;
    localparam logic [4:0] OP_SLL  = 5'd6;
    localparam logic [4:0] OP_SRL  = 5'd7;
    localparam logic [4:0] OP_MULT = 5'd8;
    localparam logic [4:0] OP_DIV  = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_LW   = 5'd12;
    localparam logic [4:0] OP_LB   = 5'd13;
    localparam logic [4:0] OP_SW   = 5'd14;
    localparam logic [4:0] OP_ADDI = 5'd15;
    localparam logic [4:0] OP_J    = 5'd16;
    localparam logic [4:0] OP_NOP  = 5'd31;

    logic [1:0]       state_q, state_d;
    logic             is_div_q, is_div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // MULT partial product / DIV remainder
    logic [WIDTH-1:0] opa_q, opa_d;     // MULT multiplicand / DIV dividend->quotient
    logic [WIDTH-1:0] opb_q, opb_d;     // MULT multiplier / DIV divisor
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             div0_q, div0_d;

    // Single-cycle result computed straight from the request inputs
    logic [WIDTH-1:0] sum, dif, one_res;
    logic             one_ovf, one_div0, one_iter, one_is_div, shift_big;

    always_comb begin
        sum        = a + b;
        dif        = a - b;
        shift_big  = (b >= WIDTH_V);
        one_res    = '0;
        one_ovf    = 1'b0;
        one_div0   = 1'b0;
        one_iter   = 1'b0;
        one_is_div = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI: begin
                one_res = sum;
                one_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_LW, OP_LB, OP_SW: one_res = sum;
            OP_SUB: begin
                one_res = dif;
                // a and ~b share sign <=> a and b differ in sign
                one_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_BEQ, OP_BNE: one_res = dif;
            OP_AND: one_res = a & b;
            OP_OR:  one_res = a | b;
            OP_NOR: one_res = ~(a | b);
            OP_SLL: one_res = shift_big ? '0 : (a << b[SHW-1:0]);
            OP_SRL: one_res = shift_big ? '0 : (a >> b[SHW-1:0]);
`ifdef ALU_FAST_MULT_EN
            OP_MULT: one_res = a * b;
`else
            OP_MULT: one_iter = 1'b1;
`endif
            OP_DIV: begin
                if (b == '0) begin
                    one_res  = '1;
                    one_div0 = 1'b1;
                end else begin
                    one_iter   = 1'b1;
                    one_is_div = 1'b1;
                end
            end
            OP_J, OP_NOP: one_res = '0;
            default:      one_res = '0;
        endcase
    end

    // One iteration step of each iterative algorithm
    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_qbit;
    logic [WIDTH-1:0] div_rem_nx, div_quo_nx;

    always_comb begin
        mul_acc_nx = opb_q[0] ? (acc_q + opa_q) : acc_q;
        // Bring down the next dividend bit; a non-negative trial keeps the subtraction
        div_shift  = {acc_q, opa_q[WIDTH-1]};
        div_diff   = div_shift - {1'b0, opb_q};
        div_qbit   = ~div_diff[WIDTH];
        div_rem_nx = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_nx = {opa_q[WIDTH-2:0], div_qbit};
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        div0_d   = div0_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (one_iter) begin
                        state_d  = ST_BUSY;
                        is_div_d = one_is_div;
                        cnt_d    = '0;
                        acc_d    = '0;
                        opa_d    = a;
                        opb_d    = b;
                    end else begin
                        state_d = ST_DONE;
                        res_d   = one_res;
                        zero_d  = (one_res == '0);
                        ovf_d   = one_ovf;
                        div0_d  = one_div0;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    acc_d = div_rem_nx;
                    opa_d = div_quo_nx;
                end else begin
                    acc_d = mul_acc_nx;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    res_d   = is_div_q ? div_quo_nx : mul_acc_nx;
                    zero_d  = ((is_div_q ? div_quo_nx : mul_acc_nx) == '0);
                    ovf_d   = 1'b0;
                    div0_d  = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            div0_q   <= div0_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_BUSY);
    assign out_valid = (state_q == ST_DONE);
    assign resultado = res_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
module tb_alu_multiciclo;

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_NOR  = 5'd5;
    localparam logic [4:0] OP_SLL  = 5'd6;
    localparam logic [4:0] OP_SRL  = 5'd7;
    localparam logic [4:0] OP_MULT = 5'd8;
    localparam logic [4:0] OP_DIV  = 5'd9;
    localparam logic [4:0] OP_BEQ  = 5'd10;
    localparam logic [4:0] OP_BNE  = 5'd11;
    localparam logic [4:0] OP_LW   = 5'd12;
    localparam logic [4:0] OP_J    = 5'd16;

`ifdef ALU_FAST_MULT_EN
    localparam int MULT_LAT  = 1;
    localparam int MULT_BUSY = 0;
`else
    localparam int MULT_LAT  = 33;
    localparam int MULT_BUSY = 32;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] resultado;
    logic        zero;
    logic        ovf;
    logic        div0;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int busy_cnt;
    int rdy_bad;

    alu_multiciclo #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (resultado),
        .zero      (zero),
        .ovf       (ovf),
        .div0      (div0),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive a request between edges; lat counts rising edges from the one that
    // accepts it up to and including the one after which out_valid is seen.
    task automatic issue(input logic [4:0] op, input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        opcode   = op;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        lat      = 0;
        busy_cnt = 0;
        rdy_bad  = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            in_valid = 1'b0;
            opcode   = OP_ADD;
            a        = 32'hDEAD_BEEF;
            b        = 32'h1234_5678;
            if (busy) busy_cnt++;
            if (in_ready) rdy_bad++;
        end while (!out_valid && lat < 200);
        if (!out_valid) check("timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [4:0] op,
                            input logic [31:0] aa, input logic [31:0] bb,
                            input logic [31:0] e_res, input logic e_zero,
                            input logic e_ovf, input logic e_div0, input int e_lat);
        issue(op, aa, bb);
        check({tag, ".res"},  resultado, e_res);
        check({tag, ".zero"}, 32'(zero), 32'(e_zero));
        check({tag, ".ovf"},  32'(ovf),  32'(e_ovf));
        check({tag, ".div0"}, 32'(div0), 32'(e_div0));
        check({tag, ".lat"},  32'(lat),  32'(e_lat));
        check({tag, ".rdy"},  32'(rdy_bad), 32'd0);
        consume();
        check({tag, ".idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 5'd0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.res",       resultado,      32'd0);
        check("rst.flags",     {29'd0, zero, ovf, div0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op_check("add",   OP_ADD,  32'd5, 32'd3, 32'd8, 1'b0, 1'b0, 1'b0, 1);
        op_check("sub0",  OP_SUB,  32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1);
        op_check("addov", OP_ADD,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
        op_check("subov", OP_SUB,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1);
        op_check("nor",   OP_NOR,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0, 1'b0, 1'b0, 1);
        op_check("and",   OP_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1);
        op_check("or",    OP_OR,   32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF, 1'b0, 1'b0, 1'b0, 1);
        op_check("sll40", OP_SLL,  32'h1, 32'd40, 32'd0, 1'b1, 1'b0, 1'b0, 1);
        op_check("sll31", OP_SLL,  32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1);
        op_check("srl31", OP_SRL,  32'h8000_0000, 32'd31, 32'h1, 1'b0, 1'b0, 1'b0, 1);
        op_check("srl32", OP_SRL,  32'hFFFF_FFFF, 32'd32, 32'd0, 1'b1, 1'b0, 1'b0, 1);
        op_check("beq",   OP_BEQ,  32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0, 1);
        op_check("bne",   OP_BNE,  32'd7, 32'd8, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1);
        op_check("lw",    OP_LW,   32'h100, 32'h4, 32'h104, 1'b0, 1'b0, 1'b0, 1);
        op_check("j",     OP_J,    32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0, 1);
        op_check("undef", 5'd20,   32'd5, 32'd6, 32'd0, 1'b1, 1'b0, 1'b0, 1);

        op_check("mult",  OP_MULT, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, 1'b0, MULT_LAT);
        check("mult.busy", 32'(busy_cnt), 32'(MULT_BUSY));
        op_check("multw", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, MULT_LAT);
        op_check("mult0", OP_MULT, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0, MULT_LAT);

        op_check("div",   OP_DIV,  32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, 33);
        check("div.busy", 32'(busy_cnt), 32'd32);
        op_check("div1",  OP_DIV,  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33);
        op_check("divbig", OP_DIV, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 1'b0, 1'b0, 1'b0, 33);
        op_check("div0",  OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1);
        check("div0.busy", 32'(busy_cnt), 32'd0);

        // Backpressure: result held for 3 cycles while a new request is offered
        issue(OP_ADD, 32'd10, 32'd20);
        check("bp.first", resultado, 32'd30);
        opcode   = OP_SUB;
        a        = 32'd1;
        b        = 32'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp.res",   resultado, 32'd30);
            check("bp.flags", {29'd0, zero, ovf, div0}, 32'd0);
            check("bp.hs",    {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid = 1'b0;
        consume();
        @(posedge clk);
        #1;
        check("bp.noaccept", {29'd0, out_valid, busy, in_ready}, 32'd1);
        check("bp.hold",     resultado, 32'd30);

        // Reset 10 cycles into a DIV
        @(negedge clk);
        opcode   = OP_DIV;
        a        = 32'd100;
        b        = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("rdiv.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rrst.res",   resultado, 32'd0);
        check("rrst.flags", {29'd0, zero, ovf, div0}, 32'd0);
        check("rrst.hs",    {29'd0, out_valid, busy, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rdy_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) rdy_bad++;
        end
        check("rrst.stale", 32'(rdy_bad), 32'd0);
        op_check("radd",  OP_ADD,  32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
